// File: rtl/wheel_drive_guard.sv
// ============================================================================
// wheel_drive_guard : per-wheel dead-time guard between the drive controller
// and the H-bridge pins, with global enable and sticky invalid-code faults.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wheel_drive_guard #(
  parameter int DEAD_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drive_en,
  input  logic       fault_clr,
  input  logic       speed_pwm_in_1,
  input  logic       speed_pwm_in_2,
  input  logic [1:0] ctrl_in_1,
  input  logic [1:0] ctrl_in_2,
  output logic       speed_pwm_out_1,
  output logic       speed_pwm_out_2,
  output logic [1:0] ctrl_out_1,
  output logic [1:0] ctrl_out_2,
  output logic [1:0] dead_active,
  output logic [1:0] fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_REV  = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  localparam logic [1:0]       c_coast     = 2'b00;
  localparam logic [1:0]       c_fwd       = 2'b10;
  localparam logic [1:0]       c_rev       = 2'b01;
  localparam logic [1:0]       c_invalid   = 2'b11;
  localparam logic [CNT_W-1:0] c_dead_load = CNT_W'(DEAD_CYCLES - 1);

  logic [1:0] w_code   [2];
  logic       w_pwm_in [2];
  logic [1:0] r_ctrl   [2];
  logic       r_pwm    [2];
  logic       r_dead   [2];
  logic       r_fault  [2];

  assign w_code[0]   = ctrl_in_1;
  assign w_code[1]   = ctrl_in_2;
  assign w_pwm_in[0] = speed_pwm_in_1;
  assign w_pwm_in[1] = speed_pwm_in_2;

  assign ctrl_out_1      = r_ctrl[0];
  assign ctrl_out_2      = r_ctrl[1];
  assign speed_pwm_out_1 = r_pwm[0];
  assign speed_pwm_out_2 = r_pwm[1];
  assign dead_active     = {r_dead[1], r_dead[0]};
  assign fault           = {r_fault[1], r_fault[0]};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_wheel
      state_t           r_state;
      state_t           w_next;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic [1:0]       w_req;
      logic             w_drive;

      always_comb begin
        w_req      = (!drive_en || (w_code[i] == c_invalid)) ? c_coast : w_code[i];
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
          S_IDLE: begin
            if (w_req == c_fwd)      w_next = S_FWD;
            else if (w_req == c_rev) w_next = S_REV;
          end
          S_FWD: begin
            if (w_req != c_fwd) begin
              w_next     = S_DEAD;
              w_cnt_next = c_dead_load;
            end
          end
          S_REV: begin
            if (w_req != c_rev) begin
              w_next     = S_DEAD;
              w_cnt_next = c_dead_load;
            end
          end
          S_DEAD: begin
            // The interval always runs to completion; the request is only
            // honoured on the final count.
            if (r_cnt != '0) begin
              w_cnt_next = r_cnt - CNT_W'(1);
            end else if (w_req == c_fwd) begin
              w_next = S_FWD;
            end else if (w_req == c_rev) begin
              w_next = S_REV;
            end else begin
              w_next = S_IDLE;
            end
          end
          default: w_next = S_IDLE;
        endcase
        w_drive = (w_next == S_FWD) || (w_next == S_REV);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_ctrl[i]  <= c_coast;
          r_pwm[i]   <= 1'b0;
          r_dead[i]  <= 1'b0;
          r_fault[i] <= 1'b0;
        end else begin
          r_state   <= w_next;
          r_cnt     <= w_cnt_next;
          r_ctrl[i] <= (w_next == S_FWD) ? c_fwd :
                       (w_next == S_REV) ? c_rev : c_coast;
          r_pwm[i]  <= w_pwm_in[i] & w_drive;
          r_dead[i] <= (w_next == S_DEAD);
          if (w_code[i] == c_invalid) r_fault[i] <= 1'b1;
          else if (fault_clr)         r_fault[i] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_wheel_drive_guard.sv
// ============================================================================
// tb_wheel_drive_guard : directed stimulus against a cycle-level reference
// model of the wheel dead-time guard. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wheel_drive_guard;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drive_en = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pwm_in_1 = 1'b0, pwm_in_2 = 1'b0;
  logic [1:0] ctrl_in_1 = 2'b00, ctrl_in_2 = 2'b00;
  logic       pwm_out_1, pwm_out_2;
  logic [1:0] ctrl_out_1, ctrl_out_2, dead_active, fault;

  int passed = 0;
  int total  = 0;

  wheel_drive_guard #(.DEAD_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .drive_en(drive_en), .fault_clr(fault_clr),
    .speed_pwm_in_1(pwm_in_1), .speed_pwm_in_2(pwm_in_2),
    .ctrl_in_1(ctrl_in_1), .ctrl_in_2(ctrl_in_2),
    .speed_pwm_out_1(pwm_out_1), .speed_pwm_out_2(pwm_out_2),
    .ctrl_out_1(ctrl_out_1), .ctrl_out_2(ctrl_out_2),
    .dead_active(dead_active), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: direction as +1/-1/0, and the number of coast cycles
  // still owed (0 means not coasting for dead time).
  int         m_dir [2];
  int         m_left[2];
  logic       m_pwm [2];
  logic [1:0] m_fault;

  function automatic int req_dir(input logic en, input logic [1:0] code);
    if (!en)            return 0;
    if (code == 2'b10)  return 1;
    if (code == 2'b01)  return -1;
    return 0;
  endfunction

  function automatic logic [1:0] dir_code(input int dir, input int left);
    if (left != 0) return 2'b00;
    if (dir == 1)  return 2'b10;
    if (dir == -1) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic [1:0] code[2];
    logic       pin[2];
    code[0] = ctrl_in_1; code[1] = ctrl_in_2;
    pin[0]  = pwm_in_1;  pin[1]  = pwm_in_2;
    if (!rst_n) begin
      for (int w = 0; w < 2; w++) begin
        m_dir[w] = 0; m_left[w] = 0; m_pwm[w] = 1'b0;
      end
      m_fault = 2'b00;
    end else begin
      for (int w = 0; w < 2; w++) begin
        int r;
        r = req_dir(drive_en, code[w]);
        if (m_left[w] > 1) begin
          m_left[w]--;
        end else if (m_left[w] == 1) begin
          m_left[w] = 0;
          m_dir[w]  = r;
        end else if (m_dir[w] != 0 && r != m_dir[w]) begin
          m_left[w] = D;
          m_dir[w]  = 0;
        end else begin
          m_dir[w] = r;
        end
        m_pwm[w] = pin[w] & (m_dir[w] != 0) & (m_left[w] == 0);
        if (code[w] == 2'b11) m_fault[w] = 1'b1;
        else if (fault_clr)   m_fault[w] = 1'b0;
      end
    end
    #1;
    check("model ctrl_out_1", {6'd0, ctrl_out_1}, {6'd0, dir_code(m_dir[0], m_left[0])});
    check("model ctrl_out_2", {6'd0, ctrl_out_2}, {6'd0, dir_code(m_dir[1], m_left[1])});
    check("model pwm_out_1", {7'd0, pwm_out_1}, {7'd0, m_pwm[0]});
    check("model pwm_out_2", {7'd0, pwm_out_2}, {7'd0, m_pwm[1]});
    check("model dead_active", {6'd0, dead_active},
          {6'd0, (m_left[1] != 0), (m_left[0] != 0)});
    check("model fault", {6'd0, fault}, {6'd0, m_fault});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drive_en  = 1'b1;
    ctrl_in_1 = 2'b10; pwm_in_1 = 1'b1;
    ctrl_in_2 = 2'b01; pwm_in_2 = 1'b1;
    cyc(2);
    check("reset ctrl_out_1", {6'd0, ctrl_out_1}, 8'h00);
    check("reset pwm_out_1", {7'd0, pwm_out_1}, 8'h00);
    check("reset dead/fault", {4'd0, dead_active, fault}, 8'h00);
    rst_n = 1'b1;
    cyc(1);
    check("start fwd ctrl_out_1", {6'd0, ctrl_out_1}, 8'h02);
    check("start fwd pwm_out_1", {7'd0, pwm_out_1}, 8'h01);
    check("start rev ctrl_out_2", {6'd0, ctrl_out_2}, 8'h01);

    // Forward to reverse: four coast cycles, then reverse.
    ctrl_in_1 = 2'b01;
    cyc(1);
    check("fwd->rev coast", {6'd0, ctrl_out_1}, 8'h00);
    check("fwd->rev dead", {6'd0, dead_active}, 8'h01);
    check("fwd->rev pwm", {7'd0, pwm_out_1}, 8'h00);
    cyc(3);
    check("fwd->rev dead last", {6'd0, dead_active}, 8'h01);
    cyc(1);
    check("fwd->rev done", {6'd0, ctrl_out_1}, 8'h01);
    check("wheel 2 untouched", {6'd0, ctrl_out_2}, 8'h01);

    // Request returns to the old direction mid-coast: full interval anyway.
    ctrl_in_1 = 2'b10;
    cyc(2);
    ctrl_in_1 = 2'b01;
    cyc(2);
    check("return mid-dead still dead", {6'd0, dead_active}, 8'h01);
    cyc(1);
    check("return mid-dead resumes", {6'd0, ctrl_out_1}, 8'h01);

    // Invalid code on wheel 2 while in reverse.
    ctrl_in_2 = 2'b11;
    cyc(1);
    ctrl_in_2 = 2'b01;
    check("invalid -> fault", {6'd0, fault}, 8'h02);
    check("invalid -> dead", {6'd0, dead_active}, 8'h02);
    cyc(1);
    check("fault sticky", {6'd0, fault}, 8'h02);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("fault cleared", {6'd0, fault}, 8'h00);
    fault_clr = 1'b1; ctrl_in_2 = 2'b11;
    cyc(1);
    fault_clr = 1'b0; ctrl_in_2 = 2'b01;
    check("set beats clear", {6'd0, fault}, 8'h02);
    cyc(1);
    check("invalid mid-dead no reload", {6'd0, ctrl_out_2}, 8'h01);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;

    // Global disable while both wheels drive.
    drive_en = 1'b0;
    cyc(1);
    check("disable coast", {4'd0, ctrl_out_2, ctrl_out_1}, 8'h00);
    check("disable dead both", {6'd0, dead_active}, 8'h03);
    cyc(3);
    check("disable dead last", {6'd0, dead_active}, 8'h03);
    cyc(1);
    check("disable idle", {6'd0, dead_active}, 8'h00);
    drive_en = 1'b1;
    cyc(1);
    check("re-enable drive", {4'd0, ctrl_out_2, ctrl_out_1}, 8'h05);

    // Reset in the middle of a coast interval.
    ctrl_in_1 = 2'b10;
    cyc(1);
    #3 rst_n = 1'b0;
    #1;
    check("async reset outputs", {ctrl_out_2, ctrl_out_1, dead_active, pwm_out_2, pwm_out_1}, 8'h00);
    cyc(1);
    ctrl_in_1 = 2'b01;
    rst_n = 1'b1;
    cyc(1);
    check("post-reset rev", {6'd0, ctrl_out_1}, 8'h01);
    check("post-reset no dead", {6'd0, dead_active}, 8'h00);

    // PWM gating follows the input with one cycle of delay.
    for (int k = 0; k < 6; k++) begin
      pwm_in_1 = k[0];
      pwm_in_2 = k[1];
      cyc(1);
    end
    ctrl_in_1 = 2'b00;
    cyc(D + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
